// File: rtl/vga_scaled.sv
// VGA timing generator that scales a frame-buffer image by repeating each
// source pixel (pixel_div+1) clocks wide and each source row (line_div+1) lines tall.
module vga_scaled #(
  parameter int H_VISIBLE     = 800,
  parameter int H_FRONT_PORCH = 40,
  parameter int H_SYNC_PULSE  = 128,
  parameter int H_BACK_PORCH  = 88,
  parameter int V_VISIBLE     = 600,
  parameter int V_FRONT_PORCH = 1,
  parameter int V_SYNC_PULSE  = 4,
  parameter int V_BACK_PORCH  = 23,
  parameter int GRAY_WIDTH    = 4,
  parameter int WIDTH_DIV     = 4,
  parameter bit H_SYNC_POL    = 1'b1,
  parameter bit V_SYNC_POL    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_DIV-1:0]  pixel_div,
  input  logic [WIDTH_DIV-1:0]  line_div,
  output logic                  h_sync_out,
  output logic                  v_sync_out,
  output logic [GRAY_WIDTH-1:0] gray_out,
  output logic                  visible_out,
  input  logic [GRAY_WIDTH-1:0] frame_pixel_in,
  input  logic                  frame_valid_in,
  output logic                  frame_next_pixel_out,
  output logic                  frame_line_restart_out,
  output logic                  frame_reset_out,
  output logic                  underrun_out
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0]        h_ctr;
  logic [VW-1:0]        v_ctr;
  logic [WIDTH_DIV-1:0] sub_ctr, rep_ctr;
  logic [WIDTH_DIV-1:0] pixel_div_shadow, line_div_shadow, pixel_div_eff;
  logic frame_start, h_last, v_last, h_vis, v_vis, visible, fetch;
  logic h_sync_act, v_sync_act;

  always_comb begin
    frame_start = (h_ctr == '0) && (v_ctr == '0);
    h_last      = (h_ctr == HW'(H_TOTAL - 1));
    v_last      = (v_ctr == VW'(V_TOTAL - 1));
    h_vis       = (h_ctr < HW'(H_VISIBLE));
    v_vis       = (v_ctr < VW'(V_VISIBLE));
    visible     = h_vis && v_vis;
    // The shadow is loaded on this very cycle, so the first pixel of a frame
    // must already see the new divider.
    pixel_div_eff = frame_start ? pixel_div : pixel_div_shadow;
    fetch       = visible && (sub_ctr == '0);
    h_sync_act  = (h_ctr >= HW'(H_VISIBLE + H_FRONT_PORCH)) &&
                  (h_ctr <= HW'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE - 1));
    v_sync_act  = (v_ctr >= VW'(V_VISIBLE + V_FRONT_PORCH)) &&
                  (v_ctr <= VW'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_ctr                  <= '0;
      v_ctr                  <= '0;
      sub_ctr                <= '0;
      rep_ctr                <= '0;
      pixel_div_shadow       <= '0;
      line_div_shadow        <= '0;
      h_sync_out             <= !H_SYNC_POL;
      v_sync_out             <= !V_SYNC_POL;
      gray_out               <= '0;
      visible_out            <= 1'b0;
      frame_next_pixel_out   <= 1'b0;
      frame_line_restart_out <= 1'b0;
      frame_reset_out        <= 1'b0;
      underrun_out           <= 1'b0;
    end else begin
      h_ctr <= h_last ? '0 : h_ctr + 1'b1;
      if (h_last) v_ctr <= v_last ? '0 : v_ctr + 1'b1;

      if (frame_start) begin
        pixel_div_shadow <= pixel_div;
        line_div_shadow  <= line_div;
      end

      if (h_last)     sub_ctr <= '0;
      else if (h_vis) sub_ctr <= (sub_ctr == pixel_div_eff) ? '0 : sub_ctr + 1'b1;

      if (h_last) begin
        if (v_last)     rep_ctr <= '0;
        else if (v_vis) rep_ctr <= (rep_ctr == line_div_shadow) ? '0 : rep_ctr + 1'b1;
      end

      h_sync_out  <= h_sync_act ? H_SYNC_POL : !H_SYNC_POL;
      v_sync_out  <= v_sync_act ? V_SYNC_POL : !V_SYNC_POL;
      visible_out <= visible;

      // gray_out doubles as the pixel hold register between fetches.
      if (fetch)         gray_out <= frame_valid_in ? frame_pixel_in : '0;
      else if (!visible) gray_out <= '0;

      frame_next_pixel_out   <= fetch && frame_valid_in;
      frame_line_restart_out <= (h_ctr == HW'(H_VISIBLE)) && v_vis &&
                                (rep_ctr != line_div_shadow);
      frame_reset_out        <= (h_ctr == '0) && (v_ctr == VW'(V_VISIBLE + V_FRONT_PORCH));

      if (frame_start)                   underrun_out <= fetch && !frame_valid_in;
      else if (fetch && !frame_valid_in) underrun_out <= 1'b1;
    end
  end
endmodule
